// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared stage indices, FSM states and stall sources
package pipe_hazard_ctrl_pkg;

  localparam int STAGE_CNT = 6;

  localparam int STG_IF   = 0;
  localparam int STG_ID   = 1;
  localparam int STG_EX   = 2;
  localparam int STG_MEM1 = 3;
  localparam int STG_MEM2 = 4;
  localparam int STG_WB   = 5;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_DIV_WAIT   = 2'd1,
    ST_EXCP_DRAIN = 2'd2
  } hz_state_e;

  typedef enum logic [2:0] {
    SRC_NONE = 3'd0,
    SRC_MEM  = 3'd1,
    SRC_DIV  = 3'd2,
    SRC_HAZ  = 3'd3,
    SRC_IF   = 3'd4
  } stall_src_e;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// rtl/pipe_hazard_ctrl_sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clear,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stall/flush scheduler with divider and exception sequencing
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int DIV_MAX = 34,
  parameter int CNT_W   = 32,
  parameter int STAGES  = STAGE_CNT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic              id_data_valid_a,
  input  logic              id_data_valid_b,
  input  logic              if_req_stall,
  input  logic              mem_req_stall,
  input  logic              ex_div_start,
  input  logic              div_done,
  input  logic              branch_flush,
  input  logic              excp_flush,
  output logic [STAGES-1:0] stall,
  output logic [STAGES-1:0] flush,
  output logic              div_cancel,
  output logic              div_timeout,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  hazard_cycles
);

  localparam int DCW = $clog2(DIV_MAX + 1);

  hz_state_e        state_q, state_d;
  logic [DCW-1:0]   div_cnt_q, div_cnt_d;
  logic             div_timeout_q, div_timeout_d;

  logic             id_hazard;
  stall_src_e       src;
  logic [STAGES-1:0] stall_c;
  logic [STAGES-1:0] flush_c;
  logic             haz_sel;

  assign id_hazard = id_valid && !(id_data_valid_a && id_data_valid_b);

  always_comb begin
    state_d       = state_q;
    div_cnt_d     = div_cnt_q;
    div_timeout_d = div_timeout_q;
    if (excp_flush) begin
      state_d   = ST_EXCP_DRAIN;
      div_cnt_d = '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (ex_div_start) begin
            state_d   = ST_DIV_WAIT;
            div_cnt_d = '0;
          end
        end
        ST_DIV_WAIT: begin
          if (div_done) begin
            state_d   = ST_RUN;
            div_cnt_d = '0;
          end else if (div_cnt_q == DCW'(DIV_MAX - 1)) begin
            // this is the DIV_MAX-th waiting cycle: give up and release EX
            state_d       = ST_RUN;
            div_cnt_d     = '0;
            div_timeout_d = TRUE;
          end else begin
            div_cnt_d = div_cnt_q + DCW'(1);
          end
        end
        ST_EXCP_DRAIN: state_d = ST_RUN;
        default:       state_d = ST_RUN;
      endcase
    end
  end

  always_comb begin
    src = SRC_NONE;
    if (mem_req_stall) begin
      src = SRC_MEM;
    end else if ((state_q == ST_DIV_WAIT) && !div_done) begin
      src = SRC_DIV;
    end else if (id_hazard) begin
      src = SRC_HAZ;
    end else if (if_req_stall) begin
      src = SRC_IF;
    end
  end

  always_comb begin
    stall_c = '0;
    flush_c = '0;
    haz_sel = FALSE;
    if (!rst_n) begin
      flush_c = '1;
    end else if (excp_flush) begin
      flush_c[STG_MEM2:STG_IF] = '1;
    end else if (state_q == ST_EXCP_DRAIN) begin
      flush_c[STG_IF] = TRUE;
    end else begin
      case (src)
        SRC_MEM: begin
          stall_c[STG_MEM1:STG_IF] = '1;
          flush_c[STG_MEM2]        = TRUE;
        end
        SRC_DIV: begin
          stall_c[STG_EX:STG_IF] = '1;
          flush_c[STG_MEM1]      = TRUE;
        end
        SRC_HAZ: begin
          stall_c[STG_ID:STG_IF] = '1;
          flush_c[STG_EX]        = TRUE;
          haz_sel                = TRUE;
        end
        SRC_IF: begin
          stall_c[STG_IF] = TRUE;
          flush_c[STG_ID] = TRUE;
        end
        default: ;
      endcase
      // a redirect can only be taken while EX moves; otherwise EX keeps requesting it
      if (branch_flush && !stall_c[STG_EX]) begin
        stall_c[STG_ID:STG_IF] = '0;
        flush_c[STG_ID:STG_IF] = '1;
        haz_sel                = FALSE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      div_cnt_q     <= '0;
      div_timeout_q <= FALSE;
    end else begin
      state_q       <= state_d;
      div_cnt_q     <= div_cnt_d;
      div_timeout_q <= div_timeout_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (|stall_c),
    .clear (FALSE),
    .count (stall_cycles)
  );

  sat_counter #(.CNT_W(CNT_W)) u_hazard_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (haz_sel),
    .clear (FALSE),
    .count (hazard_cycles)
  );

  assign stall       = stall_c;
  assign flush       = flush_c;
  assign div_cancel  = excp_flush && (state_q == ST_DIV_WAIT);
  assign div_timeout = div_timeout_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  localparam logic [8:0] I_V  = 9'h100;
  localparam logic [8:0] I_A  = 9'h080;
  localparam logic [8:0] I_B  = 9'h040;
  localparam logic [8:0] I_IF = 9'h020;
  localparam logic [8:0] I_M  = 9'h010;
  localparam logic [8:0] I_DS = 9'h008;
  localparam logic [8:0] I_DD = 9'h004;
  localparam logic [8:0] I_BR = 9'h002;
  localparam logic [8:0] I_EX = 9'h001;

  typedef struct {
    logic [5:0] s;
    logic [5:0] f;
    logic       c;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst_req = 1'b0;
  logic id_valid = 1'b0, id_data_valid_a = 1'b0, id_data_valid_b = 1'b0;
  logic if_req_stall = 1'b0, mem_req_stall = 1'b0, ex_div_start = 1'b0;
  logic div_done = 1'b0, branch_flush = 1'b0, excp_flush = 1'b0;

  logic [5:0]  stall, flush, stall_s, flush_s;
  logic        div_cancel, div_timeout, div_cancel_s, div_timeout_s;
  logic [31:0] stall_cycles, hazard_cycles;
  logic [2:0]  stall_cycles_s, hazard_cycles_s;

  int   checks = 0;
  int   failures = 0;
  int   exp_stall = 0;
  int   exp_haz = 0;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.DIV_MAX(34), .CNT_W(32), .STAGES(6)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_data_valid_a(id_data_valid_a),
    .id_data_valid_b(id_data_valid_b), .if_req_stall(if_req_stall), .mem_req_stall(mem_req_stall),
    .ex_div_start(ex_div_start), .div_done(div_done), .branch_flush(branch_flush),
    .excp_flush(excp_flush), .stall(stall), .flush(flush), .div_cancel(div_cancel),
    .div_timeout(div_timeout), .stall_cycles(stall_cycles), .hazard_cycles(hazard_cycles)
  );

  pipe_hazard_ctrl #(.DIV_MAX(4), .CNT_W(3), .STAGES(6)) dut_small (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_data_valid_a(id_data_valid_a),
    .id_data_valid_b(id_data_valid_b), .if_req_stall(if_req_stall), .mem_req_stall(mem_req_stall),
    .ex_div_start(ex_div_start), .div_done(div_done), .branch_flush(branch_flush),
    .excp_flush(excp_flush), .stall(stall_s), .flush(flush_s), .div_cancel(div_cancel_s),
    .div_timeout(div_timeout_s), .stall_cycles(stall_cycles_s), .hazard_cycles(hazard_cycles_s)
  );

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      checks++;
      if (stall !== mon_e.s || flush !== mon_e.f || div_cancel !== mon_e.c) begin
        failures++;
        $display("FAIL vec t=%0t stall=%b flush=%b cancel=%b required stall=%b flush=%b cancel=%b",
                 $time, stall, flush, div_cancel, mon_e.s, mon_e.f, mon_e.c);
      end
    end
  end

  task automatic step(input logic [8:0] in, input logic [5:0] es, input logic [5:0] ef,
                      input logic ec);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rst_req;
    {id_valid, id_data_valid_a, id_data_valid_b, if_req_stall, mem_req_stall,
     ex_div_start, div_done, branch_flush, excp_flush} = in;
    e.s = es;
    e.f = ef;
    e.c = ec;
    sb.push_back(e);
    if (rst_req && es != 6'b0) exp_stall++;
    if (rst_req && es == 6'b000011) exp_haz++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    step(9'h0, 6'b000000, 6'b111111, 1'b0);
    step(9'h0, 6'b000000, 6'b111111, 1'b0);
    rst_req = 1'b1;
    step(9'h0, 6'b000000, 6'b000000, 1'b0);
    check("rst_stall_cnt", stall_cycles, 0);
    check("rst_timeout", {31'b0, div_timeout}, 0);

    // ID operand hazard for two cycles, then fully forwarded operands
    step(I_V | I_B, 6'b000011, 6'b000100, 1'b0);
    step(I_V | I_B, 6'b000011, 6'b000100, 1'b0);
    step(I_V | I_A | I_B, 6'b000000, 6'b000000, 1'b0);
    check("haz_cnt_2", hazard_cycles, 2);
    check("stall_cnt_2", stall_cycles, 2);

    step(I_IF, 6'b000001, 6'b000010, 1'b0);
    step(I_BR, 6'b000000, 6'b000011, 1'b0);
    step(I_V | I_B | I_BR, 6'b000000, 6'b000111, 1'b0);

    // divide completing after five wait cycles
    step(I_DS, 6'b000000, 6'b000000, 1'b0);
    for (int i = 0; i < 5; i++) step(9'h0, 6'b000111, 6'b001000, 1'b0);
    step(I_DD, 6'b000000, 6'b000000, 1'b0);
    step(9'h0, 6'b000000, 6'b000000, 1'b0);
    check("timeout_after_done", {31'b0, div_timeout}, 0);

    step(I_M | I_V | I_B, 6'b001111, 6'b010000, 1'b0);
    step(9'h0, 6'b000000, 6'b000000, 1'b0);
    check("haz_cnt_mem", hazard_cycles, 2);

    // divide issued under a dcache miss still enters DIV_WAIT
    step(I_M | I_DS, 6'b001111, 6'b010000, 1'b0);
    step(9'h0, 6'b000111, 6'b001000, 1'b0);
    step(I_DD, 6'b000000, 6'b000000, 1'b0);

    // branch held through a divide wait
    step(I_DS, 6'b000000, 6'b000000, 1'b0);
    for (int i = 0; i < 3; i++) step(I_BR, 6'b000111, 6'b001000, 1'b0);
    step(I_BR | I_DD, 6'b000000, 6'b000011, 1'b0);
    step(9'h0, 6'b000000, 6'b000000, 1'b0);

    // exception during divide wait, then drain and back to RUN
    step(I_DS, 6'b000000, 6'b000000, 1'b0);
    step(9'h0, 6'b000111, 6'b001000, 1'b0);
    step(I_EX, 6'b000000, 6'b011111, 1'b1);
    step(9'h0, 6'b000000, 6'b000001, 1'b0);
    step(I_V | I_B, 6'b000011, 6'b000100, 1'b0);

    // exception wins over a simultaneous div_done
    step(I_DS, 6'b000000, 6'b000000, 1'b0);
    step(I_EX | I_DD, 6'b000000, 6'b011111, 1'b1);
    step(9'h0, 6'b000000, 6'b000001, 1'b0);
    step(I_EX, 6'b000000, 6'b011111, 1'b0);
    step(9'h0, 6'b000000, 6'b000001, 1'b0);
    step(9'h0, 6'b000000, 6'b000000, 1'b0);

    // divider never answers
    step(I_DS, 6'b000000, 6'b000000, 1'b0);
    for (int i = 0; i < 34; i++) step(9'h0, 6'b000111, 6'b001000, 1'b0);
    check("timeout_before_limit", {31'b0, div_timeout}, 0);
    step(9'h0, 6'b000000, 6'b000000, 1'b0);
    check("timeout_at_limit", {31'b0, div_timeout}, 1);
    step(9'h0, 6'b000000, 6'b000000, 1'b0);
    check("timeout_sticky", {31'b0, div_timeout}, 1);

    check("stall_cnt_final", stall_cycles, exp_stall);
    check("haz_cnt_final", hazard_cycles, exp_haz);
    check("small_stall_sat", {29'b0, stall_cycles_s}, 7);
    check("small_haz_cnt", {29'b0, hazard_cycles_s}, exp_haz);
    check("small_timeout", {31'b0, div_timeout_s}, 1);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain pending=%0d required=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush scheduler for the 6-stage pipeline: IF, ID, EX, MEM1, MEM2, WB.
- Consumes the two ID-stage operand-forwarding valid flags, multi-cycle divider status, cache-miss stalls, branch redirects and exception flushes.
- Produces per-stage stall and flush vectors; sequences divider wait and exception drain with a small FSM.
- Keeps saturating stall performance counters.

Parameters:
DIV_MAX, 34, max cycles waiting for div_done before div_timeout asserts
CNT_W, 32, width of performance counters
STAGES, 6, pipeline depth (bit 0 = IF ... bit 5 = WB)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a real instruction
id_data_valid_a  in  1  source A forwarded value final (from ID forwarding check)
id_data_valid_b  in  1  source B forwarded value final
if_req_stall  in  1  icache miss, IF cannot deliver
mem_req_stall  in  1  dcache miss in MEM1
ex_div_start  in  1  divide issued from EX this cycle
div_done  in  1  divider result ready
branch_flush  in  1  EX mispredict redirect; held by EX until accepted
excp_flush  in  1  exception/ertn committed at MEM2 (1-cycle pulse)
stall  out  STAGES  stall[k]=1: stage k holds its register
flush  out  STAGES  flush[k]=1: stage k register loads a bubble
div_cancel  out  1  abort in-flight divide
div_timeout  out  1  sticky; divider exceeded DIV_MAX
stall_cycles  out  CNT_W  cycles with any stall bit set, saturating
hazard_cycles  out  CNT_W  cycles stalled only by ID operand hazard, saturating

Behaviour:
- Reset (rst_n low, async): state=RUN, stall=0, flush=all ones, div_cancel=0, div_timeout=0, both counters=0, div counter=0.
- stall/flush are combinational from state and inputs; state, counters and timeout are registered.
- FSM states: RUN, DIV_WAIT, EXCP_DRAIN.
  - RUN -> DIV_WAIT on ex_div_start and not excp_flush.
  - DIV_WAIT -> RUN on div_done. div counter increments each DIV_WAIT cycle; at DIV_MAX set div_timeout and return to RUN.
  - Any state -> EXCP_DRAIN on excp_flush. EXCP_DRAIN -> RUN after exactly 1 cycle.
- Stall source priority, highest first; the first active source defines stall point p:
  - excp_flush: no stall; flush[4:0]=1.
  - EXCP_DRAIN: flush[0]=1, no stall.
  - mem_req_stall: p=MEM1.
  - DIV_WAIT and not div_done: p=EX.
  - ID hazard (id_valid and not (id_data_valid_a and id_data_valid_b)): p=ID.
  - if_req_stall: p=IF.
- Stall rule: stall[k]=1 for all k<=p; flush[p+1]=1 (bubble inserted after the stall point); all other bits 0.
- branch_flush is honoured only when stall[2]=0. It sets flush[1:0]=1 and clears stall[1:0] (IF/ID contents are wrong-path). If EX is stalled it is ignored that cycle; EX keeps it asserted.
- excp_flush in DIV_WAIT: div_cancel=1 the same cycle; div counter cleared.
- div_done and excp_flush in the same cycle: exception wins; result discarded.
- ex_div_start while mem_req_stall: transition still taken; the EX stall comes from mem priority.
- Counters:
  - stall_cycles increments when any stall bit is 1.
  - hazard_cycles increments when the ID hazard is the chosen stall source.
  - Both hold at all ones.

Decomposition:
- Shared package/defines header holds stage index constants (IF..WB), STAGES, FSM state encodings, true/false constants.
- One natural sub-module: sat_counter (CNT_W, inc, clear); instantiated twice.

Test Plan:
- Reset release, no inputs -> stall=000000, flush=000000, state RUN; during reset flush=111111.
- id_valid=1, id_data_valid_a=0 for 2 cycles -> stall=000011, flush=000100 both cycles; hazard_cycles=2, stall_cycles=2.
- ex_div_start, div_done after 5 cycles -> 5 cycles stall=000111, flush=001000; RUN on done; div_timeout=0.
- ex_div_start with div_done never asserted, DIV_MAX=34 -> div_timeout=1 after 34 cycles; stall released.
- mem_req_stall and ID hazard together -> stall=001111, flush=010000; hazard_cycles unchanged.
- branch_flush during DIV_WAIT -> no flush until div_done; then flush=000011, stall=000000.
- excp_flush during DIV_WAIT -> div_cancel=1, flush=011111, next cycle flush=000001, then RUN.
- Force counter to all ones -> holds at all ones.
